splat_fetch_ctrl: RTL and testbench

Fetch sequencer for the splat path. It issues DDR3 burst reads for a job of N 64-bit words and routes the returned data into the 32-entry splat FIFO. A credit check stops the FIFO from overflowing: FIFO count plus in-flight words plus the next burst never exceeds the FIFO depth. The block sits between the DDR3 read port and the splat FIFO write side, and owns the FIFO flush on abort.

---
 rtl/splat_pkg.sv | 7 +
 rtl/splat_credit_tracker.sv | 23 ++
 rtl/splat_fetch_ctrl.sv | 109 ++++++++++
 tb/tb_splat_fetch_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/splat_pkg.sv
// splat_pkg: shared constants, FSM state type and credit type for the splat fetch path
package splat_pkg;
  localparam int SPLAT_FIFO_DEPTH = 32;
  localparam int SPLAT_WORD_AW = 29;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} splat_fetch_state_t;
  typedef logic [6:0] credit_t;
endpackage

// File: rtl/splat_credit_tracker.sv
// splat_credit_tracker: in-flight word count and FIFO credit test for the next burst
module splat_credit_tracker
  import splat_pkg::*;
#(
  parameter int DEPTH = SPLAT_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       accept,
  input  logic [7:0] bl,
  input  logic       rdv,
  input  logic [5:0] fifo_count,
  output logic [6:0] inflight,
  output logic       fits
);
  credit_t credit;
  assign credit = credit_t'(DEPTH) - {1'b0, fifo_count} - inflight;
  assign fits = {1'b0, credit} >= bl;
  // Returns with nothing outstanding are strays and must not underflow the count.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) inflight <= '0;
    else inflight <= inflight + (accept ? credit_t'(bl) : '0) - credit_t'(rdv && inflight != '0);
endmodule

// File: rtl/splat_fetch_ctrl.sv
// splat_fetch_ctrl: DDR3 burst-read sequencer feeding the splat FIFO with credit-based flow control.
// Define SPLAT_FETCH_PERF_EN to add the credit/DDR stall counters as extra output ports.
module splat_fetch_ctrl
  import splat_pkg::*;
#(
  parameter int FIFO_DEPTH = SPLAT_FIFO_DEPTH,
  parameter int MAX_BURST = 8,
  parameter int AW = SPLAT_WORD_AW,
  parameter int LW = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [LW-1:0] length,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ddr_address,
  output logic [7:0]    ddr_burstcount,
  output logic          ddr_read,
  input  logic          ddr_waitrequest,
  input  logic          ddr_readdatavalid,
  input  logic [63:0]   ddr_readdata,
  output logic [63:0]   fifo_wr_data,
  output logic          fifo_wr_en,
  input  logic [5:0]    fifo_count,
  output logic          fifo_flush
`ifdef SPLAT_FETCH_PERF_EN
  ,
  output logic [31:0]   perf_credit_stall,
  output logic [31:0]   perf_ddr_stall
`endif
);
  splat_fetch_state_t state, state_nx;
  logic [AW-1:0] addr;
  logic [LW-1:0] remaining;
  logic [6:0] inflight;
  logic [7:0] bl;
  logic hold, fits, accept;
  assign bl = remaining >= LW'(MAX_BURST) ? 8'(MAX_BURST) : 8'(remaining);
  // A request stalled by waitrequest stays up regardless of abort or credit.
  assign ddr_read = hold || (state == ISSUE && !abort && remaining != '0 && fits);
  assign accept = ddr_read && !ddr_waitrequest;
  assign ddr_address = addr;
  assign ddr_burstcount = bl;
  assign fifo_wr_data = ddr_readdata;
  assign fifo_wr_en = ddr_readdatavalid && inflight != '0 && state != DRAIN;
  assign fifo_flush = state == FLUSH;
  assign busy = state != IDLE;
  splat_credit_tracker #(.DEPTH(FIFO_DEPTH)) u_credit (
    .clk(clk),
    .reset_n(reset_n),
    .accept(accept),
    .bl(bl),
    .rdv(ddr_readdatavalid),
    .fifo_count(fifo_count),
    .inflight(inflight),
    .fits(fits)
  );
  always_comb begin
    state_nx = state;
    done = 1'b0;
    unique case (state)
      IDLE: state_nx = start ? ISSUE : IDLE;
      ISSUE:
        if (abort) state_nx = DRAIN;
        else if (remaining == '0 && inflight == '0) begin
          done = 1'b1;
          state_nx = IDLE;
        end
      DRAIN: state_nx = inflight == '0 && !ddr_read ? FLUSH : DRAIN;
      FLUSH: begin
        done = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      hold <= 1'b0;
    end else begin
      state <= state_nx;
      hold <= ddr_read && ddr_waitrequest;
      if (state == IDLE && start) begin
        addr <= base_addr;
        remaining <= length;
      end else if (accept) begin
        addr <= addr + AW'(bl);
        remaining <= remaining - LW'(bl);
      end
    end
`ifdef SPLAT_FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      perf_credit_stall <= '0;
      perf_ddr_stall <= '0;
    end else if (state == IDLE && start) begin
      perf_credit_stall <= '0;
      perf_ddr_stall <= '0;
    end else begin
      if (state == ISSUE && !hold && !abort && remaining != '0 && !fits) perf_credit_stall <= perf_credit_stall + 32'd1;
      if (ddr_read && ddr_waitrequest) perf_ddr_stall <= perf_ddr_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_splat_fetch_ctrl.sv
// tb_splat_fetch_ctrl: randomized fetch jobs checked against a transaction-level burst/credit model
module tb_splat_fetch_ctrl;
  localparam int DEPTH = 32;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [28:0] base_addr = '0, ddr_address;
  logic [23:0] length = '0;
  logic [7:0] ddr_burstcount;
  logic ddr_read, busy, done, fifo_wr_en, fifo_flush;
  logic ddr_waitrequest = 1'b0, ddr_readdatavalid = 1'b0;
  logic [63:0] ddr_readdata = '0, fifo_wr_data;
  logic [5:0] fifo_count = '0;
  int total = 0, bad = 0;
  int p_wait, p_rdv, p_pop, p_stray, p_abort;
  bit job_on, aborting, flushing, held, was_aborted;
  int inflight, occ, writes, dones, flushes;
  logic [28:0] q_addr[$], acc_addr[$];
  int q_len[$], acc_len[$];
  logic [28:0] exp_a[3] = '{29'h100, 29'h108, 29'h110};
  int exp_l[3] = '{8, 8, 4};

  splat_fetch_ctrl dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .abort(abort),
    .busy(busy),
    .done(done),
    .ddr_address(ddr_address),
    .ddr_burstcount(ddr_burstcount),
    .ddr_read(ddr_read),
    .ddr_waitrequest(ddr_waitrequest),
    .ddr_readdatavalid(ddr_readdatavalid),
    .ddr_readdata(ddr_readdata),
    .fifo_wr_data(fifo_wr_data),
    .fifo_wr_en(fifo_wr_en),
    .fifo_count(fifo_count),
    .fifo_flush(fifo_flush)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    job_on = 0; aborting = 0; flushing = 0; held = 0; inflight = 0;
    q_addr.delete(); q_len.delete();
  endtask

  // One clock: drive random inputs, check outputs mid-cycle, then advance the model past the edge.
  task automatic step();
    bit e_read, e_wr, e_done, pop;
    int cr, r;
    logic [28:0] a;
    if (p_abort > 0) abort = job_on && !aborting && ($urandom_range(99) < p_abort);
    ddr_waitrequest = $urandom_range(99) < p_wait;
    ddr_readdatavalid = inflight > 0 ? $urandom_range(99) < p_rdv : $urandom_range(99) < p_stray;
    ddr_readdata = {$urandom, $urandom};
    fifo_count = 6'(occ);
    pop = occ > 0 && $urandom_range(99) < p_pop;
    @(negedge clk);
    cr = DEPTH - occ - inflight;
    e_read = held || (job_on && !aborting && !abort && q_len.size() > 0 && cr >= q_len[0]);
    e_wr = ddr_readdatavalid && inflight > 0 && !aborting;
    e_done = flushing || (job_on && !aborting && !abort && q_len.size() == 0 && inflight == 0);
    check("busy", busy, job_on);
    check("ddr_read", ddr_read, e_read);
    if (e_read) begin
      check("ddr_address", ddr_address, q_addr[0]);
      check("ddr_burstcount", ddr_burstcount, q_len[0]);
    end
    check("fifo_wr_en", fifo_wr_en, e_wr);
    if (e_wr) check("fifo_wr_data", fifo_wr_data, ddr_readdata);
    check("done", done, e_done);
    check("fifo_flush", fifo_flush, flushing);
    @(posedge clk);
    writes += int'(e_wr);
    dones += int'(e_done);
    flushes += int'(flushing);
    occ = occ + int'(e_wr) - int'(pop);
    if (flushing) begin
      job_on = 0; aborting = 0; flushing = 0;
    end else if (aborting) flushing = inflight == 0 && !e_read;
    else if (job_on && abort) begin
      aborting = 1; was_aborted = 1;
    end else if (e_done) job_on = 0;
    else if (!job_on && start) begin
      job_on = 1;
      q_addr.delete(); q_len.delete();
      a = base_addr;
      r = int'(length);
      while (r > 0) begin
        q_addr.push_back(a);
        q_len.push_back(r > 8 ? 8 : r);
        a = a + 29'(r > 8 ? 8 : r);
        r -= r > 8 ? 8 : r;
      end
    end
    if (ddr_readdatavalid && inflight > 0) inflight--;
    if (e_read && !ddr_waitrequest) begin
      acc_addr.push_back(q_addr[0]);
      acc_len.push_back(q_len[0]);
      inflight += q_len[0];
      void'(q_addr.pop_front());
      void'(q_len.pop_front());
    end
    held = e_read && ddr_waitrequest;
    #1;
  endtask

  task automatic kick(input logic [28:0] b, input int n);
    writes = 0; dones = 0; flushes = 0; was_aborted = 0;
    acc_addr.delete(); acc_len.delete();
    base_addr = b;
    length = 24'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_job();
    for (int c = 0; c < 1000 && job_on; c++) step();
    check("job_idle", busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_read"}, ddr_read, 0);
    check({tag, "_addr"}, ddr_address, 0);
    check({tag, "_bc"}, ddr_burstcount, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_flush"}, fifo_flush, 0);
    check({tag, "_wr_en"}, fifo_wr_en, 0);
  endtask

  initial begin
    int len_r;
    p_wait = 0; p_rdv = 100; p_pop = 100; p_stray = 0; p_abort = 0; occ = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    kick(29'h100, 20);
    finish_job();
    check("basic_writes", writes, 20);
    check("basic_done", dones, 1);
    check("basic_bursts", acc_len.size(), 3);
    if (acc_len.size() == 3)
      for (int i = 0; i < 3; i++) begin
        check("basic_addr", acc_addr[i], exp_a[i]);
        check("basic_len", acc_len[i], exp_l[i]);
      end

    occ = 28; p_pop = 0;
    kick(29'h2000, 8);
    repeat (10) step();
    check("stall_none", acc_len.size(), 0);
    p_pop = 100;
    finish_job();
    check("stall_one", acc_len.size(), 1);
    check("stall_writes", writes, 8);

    occ = 0; p_wait = 100;
    kick(29'h3000, 8);
    repeat (5) step();
    check("wait_none", acc_len.size(), 0);
    p_wait = 0;
    finish_job();
    check("wait_one", acc_len.size(), 1);

    occ = 16; p_pop = 0; p_rdv = 0;
    kick(29'h4000, 40);
    for (int c = 0; c < 20 && inflight < 16; c++) step();
    abort = 1'b1;
    repeat (2) step();
    abort = 1'b0;
    p_rdv = 100;
    finish_job();
    check("abort_writes", writes, 0);
    check("abort_flush", flushes, 1);
    check("abort_done", dones, 1);
    check("abort_bursts", acc_len.size(), 2);

    occ = 0; p_pop = 100; p_stray = 100;
    repeat (4) step();
    p_stray = 0;
    kick(29'h0, 0);
    finish_job();
    check("zero_done", dones, 1);
    check("zero_bursts", acc_len.size(), 0);
    kick(29'h5000, 5);
    finish_job();
    check("post_stray_writes", writes, 5);

    p_rdv = 50;
    kick(29'h6000, 40);
    repeat (6) step();
    #3 reset_n = 1'b0;
    ddr_readdatavalid = 1'b1;
    #1 check_reset_outputs("async");
    ddr_readdatavalid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    occ = 0;

    p_stray = 5;
    for (int j = 0; j < 40; j++) begin
      p_wait = $urandom_range(60);
      p_rdv = $urandom_range(100, 20);
      p_pop = $urandom_range(100, 20);
      p_abort = $urandom_range(3);
      occ = $urandom_range(DEPTH);
      len_r = $urandom_range(45);
      kick(29'($urandom), len_r);
      finish_job();
      if (was_aborted) check("rand_flush", flushes, 1);
      else check("rand_writes", writes, len_r);
      check("rand_done", dones, 1);
    end
    abort = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
